// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: bus word, RAM handshake state and the arbiter FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        IACC,
        DRD,
        DWR,
        IRSP,
        DRSP
    } arbstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache request and RAM port bundle; the arbiter is the slave, caches and RAM sit on master.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    logic      dREN;
    logic      dWEN;
    word_t     iaddr;
    word_t     daddr;
    word_t     dstore;
    logic      iwait;
    logic      dwait;
    word_t     iload;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      err;

    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises i/d cache requests onto one RAM port; data first with one-shot fairness,
// timeout and sticky error on RAM faults.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter word_t       ERRWORD = 32'hBAD1BAD1
) (
    input logic           CLK,
    input logic           nRST,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arbstate_t     state, next_state;
    word_t         req_addr, req_data;
    word_t         iload, dload;
    logic [CW-1:0] counter;
    logic          fair, err;

    logic  grant_i, grant_d, in_access, fail, finish;
    logic  ramREN, ramWEN, iwait, dwait;
    word_t ramaddr, ramstore;

    assign in_access = (state == IACC) || (state == DRD) || (state == DWR);
    // ACCESS wins over a coincident timeout
    assign fail   = (bus.ramstate == ERROR) ||
                    ((counter == CW'(TIMEOUT - 1)) && (bus.ramstate != ACCESS));
    assign finish = (bus.ramstate == ACCESS) || fail;

    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        unique case (state)
            IDLE: begin
                if ((bus.dREN || bus.dWEN) && !(fair && bus.iREN)) begin
                    grant_d    = 1'b1;
                    next_state = bus.dWEN ? DWR : DRD;
                end else if (bus.iREN) begin
                    grant_i    = 1'b1;
                    next_state = IACC;
                end
            end
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = req_addr;
                if (finish) next_state = IRSP;
            end
            DRD: begin
                ramREN  = 1'b1;
                ramaddr = req_addr;
                if (finish) next_state = DRSP;
            end
            DWR: begin
                ramWEN   = 1'b1;
                ramaddr  = req_addr;
                ramstore = req_data;
                if (finish) next_state = DRSP;
            end
            IRSP: begin
                iwait      = 1'b0;
                next_state = IDLE;
            end
            DRSP: begin
                dwait      = 1'b0;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            req_addr <= '0;
            req_data <= '0;
            iload    <= '0;
            dload    <= '0;
            counter  <= '0;
            fair     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= next_state;
            if (grant_i || grant_d) begin
                req_addr <= grant_d ? bus.daddr : bus.iaddr;
                req_data <= bus.dstore;
                counter  <= '0;
            end
            if (in_access) counter <= counter + 1'b1;
            if (grant_i) fair <= 1'b0;
            if (state == DRSP) fair <= 1'b1;
            if (in_access && finish) begin
                if (fail) err <= 1'b1;
                if (state == IACC) iload <= fail ? ERRWORD : bus.ramload;
                if (state == DRD)  dload <= fail ? ERRWORD : bus.ramload;
            end
        end
    end

    assign bus.ramREN   = ramREN;
    assign bus.ramWEN   = ramWEN;
    assign bus.ramaddr  = ramaddr;
    assign bus.ramstore = ramstore;
    assign bus.iwait    = iwait;
    assign bus.dwait    = dwait;
    assign bus.iload    = iload;
    assign bus.dload    = dload;
    assign bus.err      = err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// against a transaction-level model of grant order, latency and returned words.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned TO   = 16;
    localparam word_t       ERRW = 32'hBAD1BAD1;

    logic CLK = 1'b0;
    logic nRST;
    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(TO), .ERRWORD(ERRW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int    n_cmp = 0;
    int    n_bad = 0;
    logic  m_fair, m_err;
    word_t m_iload, m_dload;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset;
        m_fair  = 1'b0;
        m_err   = 1'b0;
        m_iload = '0;
        m_dload = '0;
    endtask

    task automatic idle_inputs;
        bus.iREN     = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.ramstate = FREE;
        bus.ramload  = '0;
    endtask

    // Starts in an IDLE cycle; ends in the IDLE cycle after the response.
    // kind: 0 instruction, 1 data read, 2 data write. fault: 0 none, 1 ERROR, 2 stuck.
    task automatic run_txn(input string tag, input logic ri, input logic rr, input logic rw,
                           input word_t ia, input word_t da, input word_t ds, input int lat,
                           input int fault, input word_t rl, input bit hold,
                           output int kind);
        logic  isd, fin;
        word_t a;
        int    k;
        isd  = (rr | rw) && !(m_fair && ri);
        kind = isd ? (rw ? 2 : 1) : 0;
        a    = isd ? da : ia;
        bus.iREN = ri; bus.dREN = rr; bus.dWEN = rw;
        bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
        bus.ramstate = FREE;
        step;
        k   = 1;
        fin = 1'b0;
        while (!fin) begin
            n_cmp++;
            if (bus.ramREN !== (kind != 2) || bus.ramWEN !== (kind == 2) ||
                bus.ramaddr !== a || bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin
                n_bad++;
                $display("FAIL %s access k=%0d: ren=%b wen=%b addr=%h iw=%b dw=%b, required ren=%b wen=%b addr=%h iw=1 dw=1",
                         tag, k, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iwait, bus.dwait,
                         kind != 2, kind == 2, a);
            end
            if (kind == 2) begin
                n_cmp++;
                if (bus.ramstore !== ds) begin
                    n_bad++;
                    $display("FAIL %s ramstore k=%0d: got %h required %h", tag, k, bus.ramstore, ds);
                end
            end
            if (!hold) begin
                bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
                bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom;
            end
            if (fault == 2)      bus.ramstate = ($urandom_range(0, 1) != 0) ? BUSY : FREE;
            else if (k == lat)   bus.ramstate = (fault != 0) ? ERROR : ACCESS;
            else                 bus.ramstate = BUSY;
            bus.ramload = (k == lat && fault == 0) ? rl : word_t'($urandom);
            fin = (fault != 2 && k == lat) || (k == TO);
            step;
            k++;
        end
        if (fault != 0) m_err = 1'b1;
        if (kind == 0) begin m_iload = (fault != 0) ? ERRW : rl; m_fair = 1'b0; end
        if (kind == 1) m_dload = (fault != 0) ? ERRW : rl;
        if (kind != 0) m_fair = 1'b1;
        bus.ramstate = FREE;
        n_cmp++;
        if (bus.iwait !== (kind != 0) || bus.dwait !== (kind == 0) || bus.ramREN !== 1'b0 ||
            bus.ramWEN !== 1'b0 || bus.iload !== m_iload || bus.dload !== m_dload ||
            bus.err !== m_err) begin
            n_bad++;
            $display("FAIL %s response: iw=%b dw=%b ren=%b wen=%b iload=%h dload=%h err=%b, required iw=%b dw=%b ren=0 wen=0 iload=%h dload=%h err=%b",
                     tag, bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.iload, bus.dload,
                     bus.err, kind != 0, kind == 0, m_iload, m_dload, m_err);
        end
        step;
        n_cmp++;
        if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1 || bus.ramREN !== 1'b0 ||
            bus.ramWEN !== 1'b0 || bus.iload !== m_iload || bus.dload !== m_dload) begin
            n_bad++;
            $display("FAIL %s after response: iw=%b dw=%b ren=%b wen=%b iload=%h dload=%h, required iw=1 dw=1 ren=0 wen=0 iload=%h dload=%h",
                     tag, bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.iload, bus.dload,
                     m_iload, m_dload);
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        nRST = 1'b0;
        step;
        step;
        model_reset();
        n_cmp++;
        if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1 || bus.ramREN !== 1'b0 ||
            bus.ramWEN !== 1'b0 || bus.ramaddr !== '0 || bus.ramstore !== '0 ||
            bus.iload !== '0 || bus.dload !== '0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: iw=%b dw=%b ren=%b wen=%b addr=%h store=%h iload=%h dload=%h err=%b, required 1 1 0 0 0 0 0 0 0",
                     bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore,
                     bus.iload, bus.dload, bus.err);
        end
        nRST = 1'b1;
    endtask

    task automatic test_ifetch;
        int kind;
        run_txn("ifetch", 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 2, 0, 32'h8C010004, 1'b0, kind);
        n_cmp++;
        if (kind != 0 || bus.iload !== 32'h8C010004) begin
            n_bad++;
            $display("FAIL ifetch result: kind=%0d iload=%h required kind=0 iload=8c010004", kind, bus.iload);
        end
    endtask

    task automatic test_simultaneous;
        int kind;
        int exp_k[3] = '{2, 0, 2};
        for (int i = 0; i < 3; i++) begin
            run_txn("simul", 1'b1, 1'b0, 1'b1, 32'h300, 32'h200, 32'hCAFEF00D, 1 + i, 0,
                    32'h1234_0000 + i, 1'b1, kind);
            n_cmp++;
            if (kind != exp_k[i]) begin
                n_bad++;
                $display("FAIL simul order %0d: kind=%0d required %0d", i, kind, exp_k[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_conflict;
        int kind;
        run_txn("conflict", 1'b0, 1'b1, 1'b1, 32'h0, 32'h440, 32'h5555AAAA, 3, 0, 32'h0, 1'b0, kind);
    endtask

    task automatic test_fault;
        int kind;
        run_txn("fault", 1'b0, 1'b1, 1'b0, 32'h0, 32'h880, 32'h0, 2, 1, 32'h0, 1'b0, kind);
        run_txn("fault_after", 1'b1, 1'b0, 1'b0, 32'h904, 32'h0, 32'h0, 1, 0, 32'h77, 1'b0, kind);
        n_cmp++;
        if (bus.err !== 1'b1 || bus.dload !== ERRW) begin
            n_bad++;
            $display("FAIL fault sticky: err=%b dload=%h required err=1 dload=%h", bus.err, bus.dload, ERRW);
        end
    endtask

    task automatic test_timeout_reset;
        int kind;
        run_txn("timeout", 1'b0, 1'b1, 1'b0, 32'h0, 32'hC00, 32'h0, 1, 2, 32'h0, 1'b0, kind);
        bus.dREN = 1'b1; bus.daddr = 32'hD00;
        step;
        bus.dREN = 1'b0;
        bus.ramstate = BUSY;
        for (int i = 0; i < 4; i++) step;
        nRST = 1'b0;
        step;
        nRST = 1'b1;
        model_reset();
        for (int i = 0; i < TO + 4; i++) begin
            n_cmp++;
            if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1 || bus.ramREN !== 1'b0 ||
                bus.ramWEN !== 1'b0 || bus.err !== 1'b0 || bus.dload !== '0) begin
                n_bad++;
                $display("FAIL reset mid-access cyc=%0d: iw=%b dw=%b ren=%b wen=%b err=%b dload=%h",
                         i, bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err, bus.dload);
            end
            step;
        end
        bus.ramstate = FREE;
        run_txn("post_reset", 1'b1, 1'b1, 1'b0, 32'hE00, 32'hE04, 32'h0, 2, 0, 32'hABCD, 1'b0, kind);
    endtask

    task automatic test_random;
        int   kind, f, r;
        logic ri, rr, rw;
        for (int i = 0; i < 40; i++) begin
            do begin
                ri = 1'($urandom); rr = 1'($urandom); rw = 1'($urandom);
            end while (!(ri | rr | rw));
            r = $urandom_range(0, 9);
            f = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
            run_txn("random", ri, rr, rw, $urandom, $urandom, $urandom, $urandom_range(1, 5), f,
                    $urandom, 1'($urandom), kind);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_simultaneous();
        test_conflict();
        test_fault();
        test_timeout_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the cache request interface. It accepts instruction-fetch and data read/write requests from the i/d caches (iREN/dREN/dWEN), serialises them onto a single-ported RAM, and answers each one by dropping the matching wait line for exactly one cycle. Data requests have priority over instruction requests, with one-shot fairness. A timeout counter and a sticky error flag cover RAM faults.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles spent in an access state before forced completion.
- ERRWORD, 32'hBAD1BAD1: load value returned on RAM ERROR or timeout.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- iREN  in  1  instruction read request.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- iaddr  in  32  instruction address (word_t).
- daddr  in  32  data address (word_t).
- dstore  in  32  data write value (word_t).
- iwait  out  1  0 only in the instruction response cycle.
- dwait  out  1  0 only in the data response cycle.
- iload  out  32  last instruction word returned; held between responses.
- dload  out  32  last data word returned; held between responses.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- err  out  1  sticky; set on RAM ERROR or timeout.

## Operation
- States: IDLE, IACC, DRD, DWR, IRSP, DRSP.
- IDLE:
  - Sample requests.
  - Data request = dREN|dWEN. dWEN wins if both are high (DWR).
  - Grant order: data first, unless the fair bit is set and iREN is high; then instruction.
  - On grant, latch address and dstore into req_addr/req_data, clear the counter, go to IACC, DRD or DWR.
- fair bit: set when a data response completes; cleared when an instruction is granted.
- Access states:
  - ramaddr = req_addr.
  - IACC and DRD assert ramREN; DWR asserts ramWEN with ramstore = req_data.
  - The counter increments every cycle.
  - ramstate == ACCESS: capture ramload (reads only) into iload/dload; go to the matching RSP state.
  - ramstate == ERROR, or counter == TIMEOUT-1 without ACCESS: load ERRWORD into iload/dload (reads), set err, go to RSP.
  - FREE and BUSY: stay.
- RSP states:
  - Deassert ram strobes.
  - IRSP drives iwait=0; DRSP drives dwait=0.
  - Next state is IDLE unconditionally.
- A request withdrawn mid-access does not abort the access. The RAM transaction and the RSP cycle still occur; the cache ignores them.
- Addresses and data are taken only from the latched copies. Changes on iaddr/daddr/dstore after grant are ignored.
- err clears only on reset.

## Timing
- Reset values (synchronous, on the CLK edge with nRST=0):
  - state=IDLE, iwait=1, dwait=1, iload=0, dload=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - err=0, fair=0, counter=0.
- Reset mid-access abandons the transaction; ram strobes are low from the next cycle.
- Request high at edge n (IDLE) → access state from cycle n+1. If ramstate=ACCESS in cycle n+k (k≥1), the RSP cycle is n+k+1.
- Minimum latency is 2 cycles from request to wait low.
- At most one wait line is low in any cycle. A wait line is never low for two consecutive cycles.
- Back-to-back: the cycle after RSP is IDLE, so the next grant is sampled in that cycle. Sustained throughput is one transaction per 3 cycles.
- iload/dload update on the edge entering RSP, so they are valid throughout the RSP cycle.
- Timeout: the RSP cycle is cycle n+TIMEOUT+1 after a grant at n.

## Structure
- cpu_types_pkg holds:
  - word_t and ramstate_t (existing).
  - arbstate_t enum {IDLE, IACC, DRD, DWR, IRSP, DRSP} (new).
- Counter width is $clog2(TIMEOUT+1), local to the module.
- Single module, no sub-modules.
  - One always_ff for state, latches, counter, fair and err.
  - One always_comb for next state and outputs.

## Test plan
- Reset check: hold nRST=0 for 2 cycles → iwait=dwait=1, ram strobes 0, loads 0, err=0.
- Instruction fetch:
  - Stimulus: iREN=1, iaddr=0x100; RAM returns ACCESS on the 2nd access cycle with ramload=0x8C010004.
  - Required response: ramREN=1 with ramaddr=0x100; iwait=0 for one cycle with iload=0x8C010004; dwait=1 throughout.
- Simultaneous requests:
  - Stimulus: iREN, dWEN held high; daddr=0x200, dstore=0xCAFEF00D.
  - Required response: first write to 0x200 (dwait pulse), then instruction read (iwait pulse), then data again. Fairness alternates.
- Read/write conflict: dREN=dWEN=1 → treated as a write; ramREN stays 0.
- RAM fault:
  - Stimulus: ramstate=ERROR during DRD.
  - Required response: dload=0xBAD1BAD1, dwait pulse, err=1 and remains 1 after later good accesses.
- Timeout and reset:
  - Stimulus: ramstate stuck BUSY.
  - Required response: dwait pulse exactly TIMEOUT+1 cycles after grant, with err set.
  - Repeat, asserting nRST mid-access: state returns to IDLE, no wait pulse, strobes low next cycle.
